fetch_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of the pipelined core datapath. Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Buffers returned instructions, with their PCs, in a small prefetch FIFO. Presents the FIFO head as instr_f/pc_f to the F stage and flushes on branch/jump redirects from decode.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 40 ++++
 rtl/fetch_queue.sv | 81 ++++++++
 tb/tb_fetch_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch front end
package fetch_pkg;
  typedef enum logic [1:0] {FETCH_IDLE, FETCH_WAIT, FETCH_DISCARD} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'(INSTR_BYTES - 1);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush; pointers wrap at DEPTH
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  assign head  = mem[rd];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner, single-outstanding imem requester and prefetch FIFO.
// Optional FETCH_BYPASS_EN forwards an accepted ack straight to the F stage when the FIFO is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       stall_d,
  output logic                       instr_valid_f,
  output logic [31:0]                instr_f,
  output logic [31:0]                pc_f,
  output logic [31:0]                pc_plus_4_f,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  fetch_state_t state, state_n;
  logic [31:0] fetch_pc, hold_addr;
  fetch_entry_t head, head_sel, din;
  logic full, empty, accept, pop, fifo_push, fifo_pop;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == FETCH_IDLE ? (imem_req && !imem_ack ? FETCH_WAIT : FETCH_IDLE)
            : state == FETCH_WAIT ? (imem_ack ? FETCH_IDLE : redirect ? FETCH_DISCARD : FETCH_WAIT)
            : (imem_ack ? FETCH_IDLE : FETCH_DISCARD);
  end
  // reset gates the request combinationally so an in-flight request drops at once
  always_comb begin
    imem_req  = !reset && (state != FETCH_IDLE || (!full && !redirect));
    imem_addr = state == FETCH_IDLE ? fetch_pc : hold_addr;
    accept    = imem_req && imem_ack && !redirect && state != FETCH_DISCARD;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
    end else begin
      if (redirect) fetch_pc <= align_pc(redirect_pc);
      else if (accept) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
      if (state == FETCH_IDLE) hold_addr <= fetch_pc;
    end
  assign din = '{pc: fetch_pc, instr: imem_rdata};
  assign pop = instr_valid_f && !stall_d && !redirect;
`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp           = empty && accept;
  assign instr_valid_f = !empty || byp;
  assign head_sel      = byp ? din : head;
  assign fifo_push     = accept && !(byp && pop);
  assign fifo_pop      = pop && !empty;
`else
  assign instr_valid_f = !empty;
  assign head_sel      = head;
  assign fifo_push     = accept;
  assign fifo_pop      = pop;
`endif
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .flush(redirect),
    .din  (din),
    .head (head),
    .count(count),
    .full (full),
    .empty(empty)
  );
  assign instr_f     = instr_valid_f ? head_sel.instr : NOP_INSTR;
  assign pc_f        = instr_valid_f ? head_sel.pc : 32'h0;
  assign pc_plus_4_f = pc_f + 32'(INSTR_BYTES);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench with a latency-programmable memory model and an in-order PC scoreboard
module tb_fetch_queue;
  logic clk = 0, reset, imem_req, imem_ack, redirect, stall_d, instr_valid_f;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr_f, pc_f, pc_plus_4_f;
  logic [2:0] count;
  int total = 0, bad = 0, lat = 0, wcnt = 0;
  logic [31:0] sb[$];

  fetch_queue dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall_d(stall_d), .instr_valid_f(instr_valid_f),
    .instr_f(instr_f), .pc_f(pc_f), .pc_plus_4_f(pc_plus_4_f), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = memf(imem_addr);
  always @(posedge clk) wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    cyc();
    reset = 1;
    sb.delete();
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(instr_valid_f), 0);
    cyc();
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset && instr_valid_f && !stall_d && !redirect) begin
      if (sb.size() == 0) chk("sb_underflow", pc_f, 32'hFFFF_FFFF);
      else begin
        chk("sb_pc", pc_f, sb[0]);
        chk("sb_instr", instr_f, memf(sb[0]));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset = 1; redirect = 0; redirect_pc = 0; stall_d = 0; lat = 0;
    cyc(); cyc(); #1;
    chk("reset_req", 32'(imem_req), 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_valid", 32'(instr_valid_f), 0);
    chk("reset_instr", instr_f, 0);
    chk("reset_pc", pc_f, 0);
    chk("reset_count", 32'(count), 0);
    // zero-wait streaming
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) reset = 0;
      #1;
      chk("s1_req", 32'(imem_req), 1);
      chk("s1_addr", imem_addr, 32'(4 * i));
      if (i > 0) chk("s1_count", 32'(count), 1);
      sb.push_back(32'(4 * i));
    end
    // fill while stalled
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 0) begin reset = 0; stall_d = 1; end
      #1;
      chk("s2_req", 32'(imem_req), 1);
      chk("s2_addr", imem_addr, 32'(4 * i));
      chk("s2_count", 32'(count), 32'(i));
      sb.push_back(32'(4 * i));
    end
    cyc(); #1;
    chk("s2_full_req", 32'(imem_req), 0);
    chk("s2_full_count", 32'(count), 4);
    chk("s2_head_pc", pc_f, 0);
    chk("s2_pc4", pc_plus_4_f, 4);
    cyc(); stall_d = 0; #1;
    chk("s2_pop_req", 32'(imem_req), 0);
    cyc(); #1;
    chk("s2_resume_req", 32'(imem_req), 1);
    chk("s2_resume_addr", imem_addr, 32'h10);
    chk("s2_resume_count", 32'(count), 3);
    sb.push_back(32'h10);
    // 3-cycle memory at 0x40
    rst_pulse();
    cyc(); reset = 0; lat = 3; redirect = 1; redirect_pc = 32'h40; #1;
    chk("s3_redir_req", 32'(imem_req), 0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      redirect = 0;
      #1;
      chk("s3_wait_req", 32'(imem_req), 1);
      chk("s3_wait_addr", imem_addr, 32'h40);
      chk("s3_wait_valid", 32'(instr_valid_f), 0);
    end
    cyc(); #1;
    chk("s3_ack_addr", imem_addr, 32'h40);
    sb.push_back(32'h40);
    cyc(); #1;
    chk("s3_next_addr", imem_addr, 32'h44);
    chk("s3_count", 32'(count), 1);
    // reset in the middle of a WAIT
    cyc(); reset = 1; sb.delete(); #1;
    chk("s6_req_drop", 32'(imem_req), 0);
    chk("s6_valid", 32'(instr_valid_f), 0);
    chk("s6_addr", imem_addr, 0);
    cyc();
    cyc(); reset = 0; #1;
    chk("s6_restart_req", 32'(imem_req), 1);
    chk("s6_restart_addr", imem_addr, 0);
    // redirect while waiting -> discard
    rst_pulse();
    cyc(); reset = 0; lat = 2; redirect = 1; redirect_pc = 32'h20; #1;
    cyc(); redirect = 0; #1;
    chk("s4_addr", imem_addr, 32'h20);
    cyc(); redirect = 1; redirect_pc = 32'h100; #1;
    chk("s4_hold_req", 32'(imem_req), 1);
    chk("s4_hold_addr", imem_addr, 32'h20);
    cyc(); redirect = 0; #1;
    chk("s4_disc_addr", imem_addr, 32'h20);
    chk("s4_flush_count", 32'(count), 0);
    cyc(); lat = 0; #1;
    chk("s4_new_addr", imem_addr, 32'h100);
    chk("s4_dropped", 32'(count), 0);
    sb.push_back(32'h100);
    cyc(); #1;
    chk("s4_valid", 32'(instr_valid_f), 1);
    chk("s4_pc", pc_f, 32'h100);
    sb.push_back(32'h104);
    // redirect coincident with ack; low redirect bits ignored
    cyc(); lat = 1; #1;
    chk("s5_addr", imem_addr, 32'h108);
    cyc(); redirect = 1; redirect_pc = 32'h203; #1;
    chk("s5_ack_addr", imem_addr, 32'h108);
    cyc(); redirect = 0; #1;
    chk("s5_new_req", 32'(imem_req), 1);
    chk("s5_new_addr", imem_addr, 32'h200);
    chk("s5_count", 32'(count), 0);
    cyc(); #1;
    chk("s5_wait_addr", imem_addr, 32'h200);
    sb.push_back(32'h200);
    cyc(); #1;
    chk("s5_count1", 32'(count), 1);
    chk("s5_pc", pc_f, 32'h200);
    chk("s5_next", imem_addr, 32'h204);
    cyc(); #1;
    chk("s5_sb_drained", 32'(sb.size()), 0);
    // PC wrap at 2^32
    rst_pulse();
    cyc(); reset = 0; stall_d = 1; lat = 0; redirect = 1; redirect_pc = 32'hFFFF_FFFC; #1;
    cyc(); redirect = 0; #1;
    chk("s7_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    chk("s7_wrap_addr", imem_addr, 0);
    chk("s7_pc", pc_f, 32'hFFFF_FFFC);
    chk("s7_pc4", pc_plus_4_f, 0);
    chk("s7_instr", instr_f, memf(32'hFFFF_FFFC));
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
